tsi_buffered_bridge: RTL and testbench

TSI_BUFFERED_BRIDGE -- requirements
Module: tsi_buffered_bridge

---
 rtl/tsi_buffered_bridge_if.sv | 40 ++++
 rtl/tsi_buffered_bridge.sv | 133 +++++++++++++
 tb/tb_tsi_buffered_bridge.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsi_buffered_bridge_if.sv
// tsi_buffered_bridge_if
// Groups the four valid/ready channels around the bridge.
//   tsi_out_* : chip -> bridge  (chip-to-host words enter here)
//   host_out_*: bridge -> host  (buffered chip words leave here)
//   host_in_* : host -> bridge  (host-to-chip words enter here)
//   tsi_in_*  : bridge -> chip  (buffered host words leave here)
// Modport slave is the bridge's view; modport master is the environment's.
interface tsi_buffered_bridge_if #(
  parameter int W = 32
);
  logic         tsi_out_valid;
  logic         tsi_out_ready;
  logic [W-1:0] tsi_out_bits;

  logic         tsi_in_valid;
  logic         tsi_in_ready;
  logic [W-1:0] tsi_in_bits;

  logic         host_out_valid;
  logic         host_out_ready;
  logic [W-1:0] host_out_bits;

  logic         host_in_valid;
  logic         host_in_ready;
  logic [W-1:0] host_in_bits;

  modport slave (
    input  tsi_out_valid, tsi_out_bits, output tsi_out_ready,
    output tsi_in_valid,  tsi_in_bits,  input  tsi_in_ready,
    output host_out_valid, host_out_bits, input host_out_ready,
    input  host_in_valid, host_in_bits, output host_in_ready
  );

  modport master (
    output tsi_out_valid, tsi_out_bits, input  tsi_out_ready,
    input  tsi_in_valid,  tsi_in_bits,  output tsi_in_ready,
    input  host_out_valid, host_out_bits, output host_out_ready,
    output host_in_valid, host_in_bits, input host_in_ready
  );
endinterface

// File: rtl/tsi_buffered_bridge.sv
// tsi_buffered_bridge
// Two independent circular FIFOs between a TSI chip port and a host port:
//   OUT FIFO: bus.tsi_out_*  -> bus.host_out_*
//   IN  FIFO: bus.host_in_*  -> bus.tsi_in_*
// Ports:
//   clock, reset      : single clock, asynchronous active-high reset
//   cold_reset        : synchronous flush of both FIFOs (exit is kept)
//   bus               : the four valid/ready channels (slave modport)
//   host_exit_valid/host_exit_code : host exit report
//   exit              : first nonzero exit code, sticky until reset
//   out_count/in_count: FIFO occupancies
//   chip_id           : constant CHIPID
// Readys and valids come straight from registered counts, so there is no
// combinational path between the two sides of either FIFO.
module tsi_buffered_bridge #(
  parameter int          W      = 32,
  parameter int          DEPTH  = 4,
  parameter logic [31:0] CHIPID = 32'd0,
  localparam int         CW     = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cold_reset,
  tsi_buffered_bridge_if.slave bus,
  input  logic                 host_exit_valid,
  input  logic [31:0]          host_exit_code,
  output logic [31:0]          exit,
  output logic [CW-1:0]        out_count,
  output logic [CW-1:0]        in_count,
  output logic [31:0]          chip_id
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Index 0 = OUT FIFO, index 1 = IN FIFO.
  logic          enq_valid  [2];
  logic [W-1:0]  enq_bits   [2];
  logic          deq_ready  [2];
  logic          fifo_ready [2];
  logic          fifo_valid [2];
  logic [W-1:0]  head_bits  [2];
  logic [CW-1:0] count_q    [2];

  logic [31:0] exit_reg;

  assign enq_valid[0] = bus.tsi_out_valid;
  assign enq_bits[0]  = bus.tsi_out_bits;
  assign deq_ready[0] = bus.host_out_ready;
  assign enq_valid[1] = bus.host_in_valid;
  assign enq_bits[1]  = bus.host_in_bits;
  assign deq_ready[1] = bus.tsi_in_ready;

  assign bus.tsi_out_ready  = fifo_ready[0];
  assign bus.host_out_valid = fifo_valid[0];
  assign bus.host_out_bits  = head_bits[0];
  assign bus.host_in_ready  = fifo_ready[1];
  assign bus.tsi_in_valid   = fifo_valid[1];
  assign bus.tsi_in_bits    = head_bits[1];

  assign out_count = count_q[0];
  assign in_count  = count_q[1];
  assign exit      = exit_reg;
  assign chip_id   = CHIPID;

  function automatic logic [PW-1:0] ptr_bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    // Only the host-to-chip side stops accepting once an exit code is latched;
    // it keeps draining so the chip still sees everything already queued.
    localparam bit EXIT_GATED = (gi == 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          enq, deq;

    assign fifo_ready[gi] = (count_reg != CW'(DEPTH)) &&
                            (!EXIT_GATED || (exit_reg == 32'd0));
    assign fifo_valid[gi] = (count_reg != '0);
    assign enq            = enq_valid[gi] && fifo_ready[gi];
    assign deq            = fifo_valid[gi] && deq_ready[gi];
    // Head is read combinationally so a word is visible the cycle after it is
    // written; masked to zero when empty so stale entries never leak out.
    assign head_bits[gi]  = fifo_valid[gi] ? mem[rd_ptr_reg] : '0;
    assign count_q[gi]    = count_reg;

    always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (cold_reset) begin
        wr_ptr_next = '0;
        rd_ptr_next = '0;
        count_next  = '0;
      end else begin
        if (enq) wr_ptr_next = ptr_bump(wr_ptr_reg);
        if (deq) rd_ptr_next = ptr_bump(rd_ptr_reg);
        if (enq && !deq)      count_next = count_reg + CW'(1);
        else if (!enq && deq) count_next = count_reg - CW'(1);
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        wr_ptr_reg <= wr_ptr_next;
        rd_ptr_reg <= rd_ptr_next;
        count_reg  <= count_next;
      end
    end

    // Storage needs no reset: contents are invisible while count is zero.
    always_ff @(posedge clock) begin
      if (enq && !cold_reset) mem[wr_ptr_reg] <= enq_bits[gi];
    end
  end

  // First nonzero reported code wins; later reports are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exit_reg <= 32'd0;
    end else if ((exit_reg == 32'd0) && host_exit_valid && (host_exit_code != 32'd0)) begin
      exit_reg <= host_exit_code;
    end
  end

endmodule

// File: tb/tb_tsi_buffered_bridge.sv
module tb_tsi_buffered_bridge;

  localparam logic [31:0] CHIPID = 32'h0000_1234;

  logic        clock = 1'b0;
  logic        reset;
  logic        cold_reset;
  logic        host_exit_valid;
  logic [31:0] host_exit_code;
  logic [31:0] exit_v;
  logic [31:0] chip_id_v;
  logic [2:0]  out_count;
  logic [2:0]  in_count;

  logic        cold_reset3;
  logic        host_exit_valid3;
  logic [31:0] host_exit_code3;
  logic [31:0] exit3;
  logic [31:0] chip_id3;
  logic [1:0]  out_count3;
  logic [1:0]  in_count3;

  int vectors     = 0;
  int miscompares = 0;

  tsi_buffered_bridge_if #(.W(32)) bus ();
  tsi_buffered_bridge_if #(.W(32)) bus3 ();

  tsi_buffered_bridge #(.W(32), .DEPTH(4), .CHIPID(CHIPID)) dut (
    .clock(clock), .reset(reset), .cold_reset(cold_reset), .bus(bus),
    .host_exit_valid(host_exit_valid), .host_exit_code(host_exit_code),
    .exit(exit_v), .out_count(out_count), .in_count(in_count), .chip_id(chip_id_v)
  );

  tsi_buffered_bridge #(.W(32), .DEPTH(3), .CHIPID(32'd0)) dut3 (
    .clock(clock), .reset(reset), .cold_reset(cold_reset3), .bus(bus3),
    .host_exit_valid(host_exit_valid3), .host_exit_code(host_exit_code3),
    .exit(exit3), .out_count(out_count3), .in_count(in_count3), .chip_id(chip_id3)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    vectors++; if (out_count !== 3'd0) begin miscompares++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
    vectors++; if (in_count !== 3'd0) begin miscompares++; $display("FAIL reset_in_count: got %0d want 0", in_count); end
    vectors++; if (bus.host_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_host_out_valid: got %b want 0", bus.host_out_valid); end
    vectors++; if (bus.tsi_in_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tsi_in_valid: got %b want 0", bus.tsi_in_valid); end
    vectors++; if (bus.tsi_out_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tsi_out_ready: got %b want 1", bus.tsi_out_ready); end
    vectors++; if (bus.host_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_host_in_ready: got %b want 1", bus.host_in_ready); end
    vectors++; if (bus.host_out_bits !== 32'd0) begin miscompares++; $display("FAIL reset_host_out_bits: got %h want 0", bus.host_out_bits); end
    vectors++; if (bus.tsi_in_bits !== 32'd0) begin miscompares++; $display("FAIL reset_tsi_in_bits: got %h want 0", bus.tsi_in_bits); end
    vectors++; if (exit_v !== 32'd0) begin miscompares++; $display("FAIL reset_exit: got %h want 0", exit_v); end
    vectors++; if (chip_id_v !== 32'h0000_1234) begin miscompares++; $display("FAIL chip_id: got %h want 00001234", chip_id_v); end
    $display("reset released: counts %0d/%0d", out_count, in_count);
  endtask

  task automatic test_single_word();
    bus.tsi_out_valid = 1'b1;
    bus.tsi_out_bits  = 32'hA5;
    step();
    bus.tsi_out_valid = 1'b0;
    vectors++; if (bus.host_out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", bus.host_out_valid); end
    vectors++; if (bus.host_out_bits !== 32'hA5) begin miscompares++; $display("FAIL single_bits: got %h want a5", bus.host_out_bits); end
    vectors++; if (out_count !== 3'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", out_count); end
    $display("single word: host_out_bits=%h", bus.host_out_bits);
    bus.host_out_ready = 1'b1;
    step();
    bus.host_out_ready = 1'b0;
    vectors++; if (out_count !== 3'd0) begin miscompares++; $display("FAIL single_drain_count: got %0d want 0", out_count); end
    vectors++; if (bus.host_out_bits !== 32'd0) begin miscompares++; $display("FAIL single_empty_bits: got %h want 0", bus.host_out_bits); end
  endtask

  task automatic test_full();
    bus.tsi_in_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus.host_in_valid = 1'b1;
      bus.host_in_bits  = 32'(k);
      step();
      $display("full: pushed host word %0d, in_count=%0d", k, in_count);
    end
    bus.host_in_bits = 32'd5;
    vectors++; if (in_count !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d want 4", in_count); end
    vectors++; if (bus.host_in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", bus.host_in_ready); end
    step();
    bus.host_in_valid = 1'b0;
    vectors++; if (in_count !== 3'd4) begin miscompares++; $display("FAIL full_fifth_rejected: got %0d want 4", in_count); end
    bus.tsi_in_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      vectors++; if (bus.tsi_in_valid !== 1'b1 || bus.tsi_in_bits !== 32'(k)) begin
        miscompares++; $display("FAIL full_order_%0d: got valid=%b bits=%0d want valid=1 bits=%0d", k, bus.tsi_in_valid, bus.tsi_in_bits, k);
      end
      $display("full: chip received %0d", bus.tsi_in_bits);
      step();
    end
    bus.tsi_in_ready = 1'b0;
    vectors++; if (in_count !== 3'd0 || bus.tsi_in_valid !== 1'b0) begin miscompares++; $display("FAIL full_drained: got count=%0d valid=%b want 0/0", in_count, bus.tsi_in_valid); end
  endtask

  task automatic test_simultaneous();
    bus.tsi_out_valid = 1'b1;
    bus.tsi_out_bits  = 32'h11;
    step();
    bus.tsi_out_bits  = 32'h22;
    step();
    bus.tsi_out_bits   = 32'h33;
    bus.host_out_ready = 1'b1;
    vectors++; if (out_count !== 3'd2 || bus.host_out_bits !== 32'h11) begin miscompares++; $display("FAIL simul_pre: got count=%0d head=%h want 2/11", out_count, bus.host_out_bits); end
    step();
    bus.tsi_out_valid = 1'b0;
    vectors++; if (out_count !== 3'd2) begin miscompares++; $display("FAIL simul_count: got %0d want 2", out_count); end
    vectors++; if (bus.host_out_bits !== 32'h22) begin miscompares++; $display("FAIL simul_head1: got %h want 22", bus.host_out_bits); end
    $display("simultaneous: count=%0d head=%h", out_count, bus.host_out_bits);
    step();
    vectors++; if (bus.host_out_bits !== 32'h33 || out_count !== 3'd1) begin miscompares++; $display("FAIL simul_head2: got %h count=%0d want 33/1", bus.host_out_bits, out_count); end
    step();
    bus.host_out_ready = 1'b0;
    vectors++; if (out_count !== 3'd0) begin miscompares++; $display("FAIL simul_drained: got %0d want 0", out_count); end
  endtask

  task automatic test_wrap();
    logic [31:0] data_o [10];
    logic [31:0] data_i [10];
    int in_o = 0, out_o = 0, in_i = 0, out_i = 0, cyc = 0;
    for (int k = 0; k < 10; k++) begin
      data_o[k] = 32'hC000_0000 + 32'(k * 7 + 1);
      data_i[k] = 32'h0D00_0000 + 32'(k * 13 + 5);
    end
    while ((out_o < 10 || out_i < 10) && cyc < 400) begin
      bus3.tsi_out_valid  = (in_o < 10) && ($urandom_range(0, 3) != 0);
      bus3.tsi_out_bits   = data_o[(in_o < 10) ? in_o : 0];
      bus3.host_out_ready = ($urandom_range(0, 2) != 0);
      bus3.host_in_valid  = (in_i < 10) && ($urandom_range(0, 3) != 0);
      bus3.host_in_bits   = data_i[(in_i < 10) ? in_i : 0];
      bus3.tsi_in_ready   = ($urandom_range(0, 2) != 0);
      if (bus3.host_out_valid && bus3.host_out_ready) begin
        vectors++; if (out_o >= 10 || bus3.host_out_bits !== data_o[(out_o < 10) ? out_o : 0]) begin
          miscompares++; $display("FAIL wrap_out_%0d: got %h want %h", out_o, bus3.host_out_bits, data_o[(out_o < 10) ? out_o : 0]);
        end
        $display("wrap OUT word %0d = %h", out_o, bus3.host_out_bits);
        out_o++;
      end
      if (bus3.tsi_in_valid && bus3.tsi_in_ready) begin
        vectors++; if (out_i >= 10 || bus3.tsi_in_bits !== data_i[(out_i < 10) ? out_i : 0]) begin
          miscompares++; $display("FAIL wrap_in_%0d: got %h want %h", out_i, bus3.tsi_in_bits, data_i[(out_i < 10) ? out_i : 0]);
        end
        $display("wrap IN word %0d = %h", out_i, bus3.tsi_in_bits);
        out_i++;
      end
      if (bus3.tsi_out_valid && bus3.tsi_out_ready) in_o++;
      if (bus3.host_in_valid && bus3.host_in_ready) in_i++;
      step();
      cyc++;
    end
    bus3.tsi_out_valid  = 1'b0;
    bus3.host_out_ready = 1'b0;
    bus3.host_in_valid  = 1'b0;
    bus3.tsi_in_ready   = 1'b0;
    vectors++; if (out_o != 10 || out_i != 10) begin miscompares++; $display("FAIL wrap_timeout: got out=%0d in=%0d words want 10/10", out_o, out_i); end
    vectors++; if (out_count3 !== 2'd0 || in_count3 !== 2'd0) begin miscompares++; $display("FAIL wrap_final_counts: got %0d/%0d want 0/0", out_count3, in_count3); end
  endtask

  task automatic test_exit();
    bus.tsi_in_ready  = 1'b0;
    bus.host_in_valid = 1'b1;
    bus.host_in_bits  = 32'hAA;
    step();
    bus.host_in_bits  = 32'hBB;
    step();
    bus.host_in_valid  = 1'b0;
    host_exit_valid    = 1'b1;
    host_exit_code     = 32'd0;
    step();
    vectors++; if (exit_v !== 32'd0 || bus.host_in_ready !== 1'b1) begin miscompares++; $display("FAIL exit_zero: got exit=%0d ready=%b want 0/1", exit_v, bus.host_in_ready); end
    host_exit_code = 32'd7;
    step();
    vectors++; if (exit_v !== 32'd7) begin miscompares++; $display("FAIL exit_latch: got %0d want 7", exit_v); end
    vectors++; if (bus.host_in_ready !== 1'b0) begin miscompares++; $display("FAIL exit_ready: got %b want 0", bus.host_in_ready); end
    host_exit_code = 32'd9;
    step();
    host_exit_valid = 1'b0;
    vectors++; if (exit_v !== 32'd7) begin miscompares++; $display("FAIL exit_sticky: got %0d want 7", exit_v); end
    $display("exit: latched %0d", exit_v);
    bus.host_in_valid = 1'b1;
    bus.host_in_bits  = 32'hCC;
    step();
    bus.host_in_valid = 1'b0;
    vectors++; if (in_count !== 3'd2) begin miscompares++; $display("FAIL exit_blocks_host: got %0d want 2", in_count); end
    bus.tsi_in_ready = 1'b1;
    vectors++; if (bus.tsi_in_bits !== 32'hAA) begin miscompares++; $display("FAIL exit_drain0: got %h want aa", bus.tsi_in_bits); end
    step();
    vectors++; if (bus.tsi_in_bits !== 32'hBB) begin miscompares++; $display("FAIL exit_drain1: got %h want bb", bus.tsi_in_bits); end
    step();
    bus.tsi_in_ready = 1'b0;
    vectors++; if (in_count !== 3'd0 || exit_v !== 32'd7) begin miscompares++; $display("FAIL exit_after_drain: got count=%0d exit=%0d want 0/7", in_count, exit_v); end
  endtask

  task automatic test_async_reset();
    bus.tsi_out_valid = 1'b1;
    bus.tsi_out_bits  = 32'h55;
    step();
    step();
    bus.tsi_out_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    vectors++; if (out_count !== 3'd0 || bus.host_out_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_now: got count=%0d valid=%b want 0/0", out_count, bus.host_out_valid); end
    vectors++; if (exit_v !== 32'd0) begin miscompares++; $display("FAIL async_reset_exit: got %0d want 0", exit_v); end
    @(negedge clock);
    reset = 1'b0;
    step();
    vectors++; if (bus.tsi_out_ready !== 1'b1 || bus.host_in_ready !== 1'b1) begin miscompares++; $display("FAIL async_release_ready: got %b/%b want 1/1", bus.tsi_out_ready, bus.host_in_ready); end
    $display("async reset: counts %0d/%0d", out_count, in_count);
  endtask

  task automatic test_cold_reset();
    bus.tsi_in_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.host_in_valid = 1'b1;
      bus.host_in_bits  = 32'(k);
      bus.tsi_out_valid = (k <= 2);
      bus.tsi_out_bits  = 32'(k + 16);
      step();
    end
    bus.host_in_valid = 1'b0;
    bus.tsi_out_valid = 1'b0;
    host_exit_valid   = 1'b1;
    host_exit_code    = 32'd5;
    step();
    host_exit_valid = 1'b0;
    vectors++; if (in_count !== 3'd3 || out_count !== 3'd2) begin miscompares++; $display("FAIL cold_pre: got %0d/%0d want 3/2", in_count, out_count); end
    cold_reset        = 1'b1;
    bus.tsi_out_valid = 1'b1;
    bus.tsi_out_bits  = 32'h77;
    step();
    cold_reset        = 1'b0;
    bus.tsi_out_valid = 1'b0;
    vectors++; if (in_count !== 3'd0 || bus.tsi_in_valid !== 1'b0) begin miscompares++; $display("FAIL cold_in: got count=%0d valid=%b want 0/0", in_count, bus.tsi_in_valid); end
    vectors++; if (out_count !== 3'd0 || bus.host_out_valid !== 1'b0) begin miscompares++; $display("FAIL cold_out: got count=%0d valid=%b want 0/0", out_count, bus.host_out_valid); end
    vectors++; if (exit_v !== 32'd5) begin miscompares++; $display("FAIL cold_exit_kept: got %0d want 5", exit_v); end
    vectors++; if (bus.tsi_in_bits !== 32'd0) begin miscompares++; $display("FAIL cold_bits: got %h want 0", bus.tsi_in_bits); end
    $display("cold reset: counts %0d/%0d exit=%0d", out_count, in_count, exit_v);
  endtask

  initial begin
    reset = 1'b1; cold_reset = 1'b0; host_exit_valid = 1'b0; host_exit_code = 32'd0;
    cold_reset3 = 1'b0; host_exit_valid3 = 1'b0; host_exit_code3 = 32'd0;
    bus.tsi_out_valid = 1'b0; bus.tsi_out_bits = 32'd0; bus.tsi_in_ready = 1'b0;
    bus.host_out_ready = 1'b0; bus.host_in_valid = 1'b0; bus.host_in_bits = 32'd0;
    bus3.tsi_out_valid = 1'b0; bus3.tsi_out_bits = 32'd0; bus3.tsi_in_ready = 1'b0;
    bus3.host_out_ready = 1'b0; bus3.host_in_valid = 1'b0; bus3.host_in_bits = 32'd0;

    test_reset();
    test_single_word();
    test_full();
    test_simultaneous();
    test_wrap();
    test_exit();
    test_async_reset();
    test_cold_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
